run_ctrl: RTL and testbench

//  Run sequencer upstream of the CPU core (top). Loads an operand image into the

---
 rtl/run_ctrl.sv | 151 +++++++++++++++
 tb/tb_run_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// Run sequencer: streams an operand image into the core's data memory, releases
// the core from reset, and counts run cycles until done. Watchdog: RUN_CTRL_WDOG_EN.
module run_ctrl #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned RST_CYC  = 2,
    parameter int unsigned WDOG_CYC = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [7:0]       ld_addr,
    input  logic [7:0]       ld_data,
    input  logic             ld_last,
    output logic             dm_we,
    output logic [7:0]       dm_addr,
    output logic [7:0]       dm_di,
    output logic             cpu_rst,
    input  logic             cpu_done,
    output logic             busy,
    output logic             finished,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_cnt
);

`ifdef RUN_CTRL_WDOG_EN
    typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, DONE, TMO} state_e;
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYC - 1);
`else
    typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, DONE} state_e;
`endif

    localparam int unsigned       HOLD_W    = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYC - 1);

    state_e              state_q;
    logic                ld_ready_q;
    logic                dm_we_q;
    logic [7:0]          dm_addr_q;
    logic [7:0]          dm_di_q;
    logic                cpu_rst_q;
    logic                busy_q;
    logic                finished_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q;
`ifdef RUN_CTRL_WDOG_EN
    logic                timeout_q;
`endif

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            ld_ready_q <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= '0;
            dm_di_q    <= '0;
            cpu_rst_q  <= 1'b1;
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
            cnt_q      <= '0;
            hold_cnt_q <= '0;
`ifdef RUN_CTRL_WDOG_EN
            timeout_q  <= 1'b0;
`endif
        end else begin
            dm_we_q <= 1'b0;
            case (state_q)
                LOAD: begin
                    if (ld_valid && ld_ready_q) begin
                        dm_we_q   <= 1'b1;
                        dm_addr_q <= ld_addr;
                        dm_di_q   <= ld_data;
                        if (ld_last) begin
                            state_q    <= HOLD;
                            ld_ready_q <= 1'b0;
                            hold_cnt_q <= '0;
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_q   <= RUN;
                        cpu_rst_q <= 1'b0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    // The cycle that observes done is itself counted; done beats expiry.
                    if (cpu_done) begin
                        state_q    <= DONE;
                        cnt_q      <= cnt_d;
                        finished_q <= 1'b1;
                        cpu_rst_q  <= 1'b1;
                        busy_q     <= 1'b0;
                    end
`ifdef RUN_CTRL_WDOG_EN
                    else if (cnt_q == WDOG_LAST) begin
                        state_q   <= TMO;
                        timeout_q <= 1'b1;
                        cpu_rst_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end
`endif
                    else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    // IDLE, DONE and TMO all (re)start a load on start.
                    if (start) begin
                        state_q    <= LOAD;
                        ld_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        finished_q <= 1'b0;
                        cpu_rst_q  <= 1'b1;
                        cnt_q      <= '0;
`ifdef RUN_CTRL_WDOG_EN
                        timeout_q  <= 1'b0;
`endif
                    end
                end
            endcase
        end
    end

    assign ld_ready  = ld_ready_q;
    assign dm_we     = dm_we_q;
    assign dm_addr   = dm_addr_q;
    assign dm_di     = dm_di_q;
    assign cpu_rst   = cpu_rst_q;
    assign busy      = busy_q;
    assign finished  = finished_q;
    assign cycle_cnt = cnt_q;
`ifdef RUN_CTRL_WDOG_EN
    assign timeout   = timeout_q;
`else
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// Directed self-checking bench for run_ctrl (CNT_W=4, RST_CYC=2, WDOG_CYC=8).
// Watchdog scenario runs when RUN_CTRL_WDOG_EN is defined, saturation otherwise.
module tb_run_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, ld_valid, ld_last, cpu_done;
    logic [7:0] ld_addr, ld_data;
    logic       ld_ready, dm_we, cpu_rst, busy, finished, timeout;
    logic [7:0] dm_addr, dm_di;
    logic [3:0] cycle_cnt;

    int checks   = 0;
    int failures = 0;

    run_ctrl #(.CNT_W(4), .RST_CYC(2), .WDOG_CYC(8)) dut (
        .clk(clk), .reset(reset), .start(start),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_last(ld_last),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_di(dm_di),
        .cpu_rst(cpu_rst), .cpu_done(cpu_done),
        .busy(busy), .finished(finished), .timeout(timeout),
        .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start a run with a single last-flagged word, then wait (bounded) for RUN.
    task automatic load_one(input logic [7:0] a, input logic [7:0] d);
        start = 1'b1;
        step();
        start = 1'b0; ld_valid = 1'b1; ld_last = 1'b1; ld_addr = a; ld_data = d;
        step();
        ld_valid = 1'b0; ld_last = 1'b0;
        checks++;
        if ({dm_we, dm_addr, dm_di, cpu_rst} !== {1'b1, a, d, 1'b1}) begin
            $display("FAIL load_one_write: got %b/%h/%h/%b expected 1/%h/%h/1",
                     dm_we, dm_addr, dm_di, cpu_rst, a, d);
            failures++;
        end
        for (int i = 0; i < 10; i++) begin
            step();
            if (cpu_rst === 1'b0) break;
        end
        checks++;
        if (cpu_rst !== 1'b0) begin
            $display("FAIL load_one_run_wait: cpu_rst=%b expected 0 within 10 cycles", cpu_rst);
            failures++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        ld_addr = '0; ld_data = '0; cpu_done = 1'b0;
        step(); step();
        checks++;
        if ({ld_ready, dm_we, dm_addr, dm_di, cpu_rst, busy, finished, timeout, cycle_cnt}
            !== {1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0}) begin
            $display("FAIL reset_state: got rdy=%b we=%b a=%h d=%h rst=%b busy=%b fin=%b tmo=%b cnt=%0d",
                     ld_ready, dm_we, dm_addr, dm_di, cpu_rst, busy, finished, timeout, cycle_cnt);
            failures++;
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_load_stream();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({ld_ready, busy, cpu_rst, dm_we, cycle_cnt} !== {1'b1, 1'b1, 1'b1, 1'b0, 4'h0}) begin
            $display("FAIL load_entry: got rdy=%b busy=%b rst=%b we=%b cnt=%0d expected 1 1 1 0 0",
                     ld_ready, busy, cpu_rst, dm_we, cycle_cnt);
            failures++;
        end
        ld_valid = 1'b1; ld_addr = 8'h10; ld_data = 8'hAA; ld_last = 1'b0;
        step();
        checks++;
        if ({dm_we, dm_addr, dm_di, ld_ready} !== {1'b1, 8'h10, 8'hAA, 1'b1}) begin
            $display("FAIL write0: got we=%b a=%h d=%h rdy=%b expected 1 10 aa 1",
                     dm_we, dm_addr, dm_di, ld_ready);
            failures++;
        end
        ld_addr = 8'h11; ld_data = 8'h55; ld_last = 1'b1;
        step();
        ld_valid = 1'b0; ld_last = 1'b0;
        checks++;
        if ({dm_we, dm_addr, dm_di, ld_ready, cpu_rst} !== {1'b1, 8'h11, 8'h55, 1'b0, 1'b1}) begin
            $display("FAIL write1_last: got we=%b a=%h d=%h rdy=%b rst=%b expected 1 11 55 0 1",
                     dm_we, dm_addr, dm_di, ld_ready, cpu_rst);
            failures++;
        end
        step();
        checks++;
        if ({dm_we, cpu_rst, busy} !== {1'b0, 1'b1, 1'b1}) begin
            $display("FAIL hold_cycle2: got we=%b rst=%b busy=%b expected 0 1 1", dm_we, cpu_rst, busy);
            failures++;
        end
        step();
        checks++;
        if ({cpu_rst, busy, cycle_cnt} !== {1'b0, 1'b1, 4'h0}) begin
            $display("FAIL run_entry: got rst=%b busy=%b cnt=%0d expected 0 1 0", cpu_rst, busy, cycle_cnt);
            failures++;
        end
    endtask

    task automatic test_run_done();
        for (int i = 0; i < 6; i++) step();
        checks++;
        if ({cycle_cnt, finished, cpu_rst} !== {4'd6, 1'b0, 1'b0}) begin
            $display("FAIL run_count6: got cnt=%0d fin=%b rst=%b expected 6 0 0", cycle_cnt, finished, cpu_rst);
            failures++;
        end
        cpu_done = 1'b1;
        step();
        cpu_done = 1'b0;
        checks++;
        if ({finished, cycle_cnt, cpu_rst, busy, timeout} !== {1'b1, 4'd7, 1'b1, 1'b0, 1'b0}) begin
            $display("FAIL done_state: got fin=%b cnt=%0d rst=%b busy=%b tmo=%b expected 1 7 1 0 0",
                     finished, cycle_cnt, cpu_rst, busy, timeout);
            failures++;
        end
        step(); step();
        checks++;
        if ({finished, cycle_cnt} !== {1'b1, 4'd7}) begin
            $display("FAIL done_hold: got fin=%b cnt=%0d expected 1 7", finished, cycle_cnt);
            failures++;
        end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({finished, cycle_cnt, ld_ready, busy} !== {1'b0, 4'd0, 1'b1, 1'b1}) begin
            $display("FAIL rerun_load: got fin=%b cnt=%0d rdy=%b busy=%b expected 0 0 1 1",
                     finished, cycle_cnt, ld_ready, busy);
            failures++;
        end
    endtask

    task automatic test_reset_mid_load();
        ld_valid = 1'b1; ld_last = 1'b0;
        ld_addr = 8'h20; ld_data = 8'h01;
        step();
        ld_addr = 8'h21; ld_data = 8'h02;
        step();
        checks++;
        if ({dm_we, dm_addr, dm_di} !== {1'b1, 8'h21, 8'h02}) begin
            $display("FAIL mid_load_write: got we=%b a=%h d=%h expected 1 21 02", dm_we, dm_addr, dm_di);
            failures++;
        end
        reset = 1'b0;
        step();
        checks++;
        if ({dm_we, cpu_rst, cycle_cnt, ld_ready, busy} !== {1'b0, 1'b1, 4'd0, 1'b0, 1'b0}) begin
            $display("FAIL reset_abort: got we=%b rst=%b cnt=%0d rdy=%b busy=%b expected 0 1 0 0 0",
                     dm_we, cpu_rst, cycle_cnt, ld_ready, busy);
            failures++;
        end
        reset = 1'b1; ld_valid = 1'b0;
        step();
    endtask

    task automatic test_ignore();
        cpu_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1;
            ld_addr  = 8'($urandom);
            ld_data  = 8'($urandom);
            step();
            checks++;
            if ({dm_we, ld_ready, busy, finished} !== 4'b0000) begin
                $display("FAIL idle_ignore: got we=%b rdy=%b busy=%b fin=%b expected 0 0 0 0",
                         dm_we, ld_ready, busy, finished);
                failures++;
            end
        end
        cpu_done = 1'b0; ld_valid = 1'b0;
        load_one(8'h30, 8'h3C);
        ld_valid = 1'b1; ld_addr = 8'($urandom); ld_data = 8'($urandom); start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({dm_we, ld_ready, busy, cpu_rst, cycle_cnt} !== {1'b0, 1'b0, 1'b1, 1'b0, 4'd1}) begin
            $display("FAIL run_ignore1: got we=%b rdy=%b busy=%b rst=%b cnt=%0d expected 0 0 1 0 1",
                     dm_we, ld_ready, busy, cpu_rst, cycle_cnt);
            failures++;
        end
        step();
        ld_valid = 1'b0;
        checks++;
        if ({dm_we, busy, cycle_cnt} !== {1'b0, 1'b1, 4'd2}) begin
            $display("FAIL run_ignore2: got we=%b busy=%b cnt=%0d expected 0 1 2", dm_we, busy, cycle_cnt);
            failures++;
        end
        cpu_done = 1'b1;
        step();
        cpu_done = 1'b0;
        checks++;
        if ({finished, cycle_cnt} !== {1'b1, 4'd3}) begin
            $display("FAIL run_ignore_done: got fin=%b cnt=%0d expected 1 3", finished, cycle_cnt);
            failures++;
        end
    endtask

`ifdef RUN_CTRL_WDOG_EN
    task automatic test_watchdog();
        load_one(8'h40, 8'h44);
        for (int i = 0; i < 7; i++) step();
        checks++;
        if ({cycle_cnt, timeout, busy} !== {4'd7, 1'b0, 1'b1}) begin
            $display("FAIL wdog_pre: got cnt=%0d tmo=%b busy=%b expected 7 0 1", cycle_cnt, timeout, busy);
            failures++;
        end
        step();
        checks++;
        if ({timeout, cycle_cnt, cpu_rst, busy, finished} !== {1'b1, 4'd7, 1'b1, 1'b0, 1'b0}) begin
            $display("FAIL wdog_expire: got tmo=%b cnt=%0d rst=%b busy=%b fin=%b expected 1 7 1 0 0",
                     timeout, cycle_cnt, cpu_rst, busy, finished);
            failures++;
        end
        load_one(8'h41, 8'h45);
        checks++;
        if ({timeout, cycle_cnt} !== {1'b0, 4'd0}) begin
            $display("FAIL wdog_rerun: got tmo=%b cnt=%0d expected 0 0", timeout, cycle_cnt);
            failures++;
        end
        for (int i = 0; i < 7; i++) step();
        cpu_done = 1'b1;
        step();
        cpu_done = 1'b0;
        checks++;
        if ({finished, timeout, cycle_cnt} !== {1'b1, 1'b0, 4'd8}) begin
            $display("FAIL wdog_done_wins: got fin=%b tmo=%b cnt=%0d expected 1 0 8",
                     finished, timeout, cycle_cnt);
            failures++;
        end
    endtask
`else
    task automatic test_saturate();
        load_one(8'h50, 8'h5A);
        for (int i = 0; i < 15; i++) step();
        checks++;
        if ({cycle_cnt, finished, timeout} !== {4'd15, 1'b0, 1'b0}) begin
            $display("FAIL sat_reach: got cnt=%0d fin=%b tmo=%b expected 15 0 0", cycle_cnt, finished, timeout);
            failures++;
        end
        for (int i = 0; i < 5; i++) step();
        checks++;
        if ({cycle_cnt, busy, timeout, cpu_rst} !== {4'd15, 1'b1, 1'b0, 1'b0}) begin
            $display("FAIL sat_hold: got cnt=%0d busy=%b tmo=%b rst=%b expected 15 1 0 0",
                     cycle_cnt, busy, timeout, cpu_rst);
            failures++;
        end
        cpu_done = 1'b1;
        step();
        cpu_done = 1'b0;
        checks++;
        if ({finished, cycle_cnt} !== {1'b1, 4'd15}) begin
            $display("FAIL sat_done: got fin=%b cnt=%0d expected 1 15", finished, cycle_cnt);
            failures++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_stream();
        test_run_done();
        test_reset_mid_load();
        test_ignore();
`ifdef RUN_CTRL_WDOG_EN
        test_watchdog();
`else
        test_saturate();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
